// File: rtl/aes_pkg.sv
// Shared definitions for the inverse-AES host front end.
//   fe_state_t     : front-end FSM state encoding
//   FRAME_BITS_128 : frame length in bits for a 128-bit key (key + ciphertext)
//   SYNC_STAGES    : flop depth of each input synchronizer
package aes_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} fe_state_t;

    localparam int FRAME_BITS_128 = 256;
    localparam int SYNC_STAGES    = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered
// single-cycle rise/fall pulses. Pin-to-pulse latency is STAGES + 1 clocks.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronized level (STAGES clocks behind the pin)
//   rise, fall : one-clock pulses, one clock behind a change of level
// STAGES must be at least 2.
module sync_edge
    import aes_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              level_d;

    // NOTE: every flop here is sequential state, so all assignments use <=;
    // a blocking = would collapse the chain into fewer stages in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= '0;
            level_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], din};
            level_d <= chain[STAGES-1];
            rise    <= chain[STAGES-1] & ~level_d;
            fall    <= ~chain[STAGES-1] & level_d;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/invaes_spi_frontend.sv
// Host-facing front end for invaes_core. Shifts a key and ciphertext in over
// an oversampled 3-wire link (sck/sdi/load), holds the core in load (ce = 1)
// while a frame arrives, captures the plaintext when the core reports done,
// and shifts it back out on sdo during the following frame.
// Ports:
//   clk, reset             : system clock, synchronous active-high reset
//   sck, sdi, load         : host link, asynchronous to clk
//   sdo                    : plaintext readback, MSB first
//   host_done              : result ready for readback
//   frame_err              : sticky, last frame length was not FRAME bits
//   ce, key, cyphertext    : to invaes_core
//   core_done, core_plaintext : from invaes_core
module invaes_spi_frontend
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           host_done,
    output logic           frame_err,
    output logic           ce,
    output logic [K-1:0]   key,
    output logic [127:0]   cyphertext,
    input  logic           core_done,
    input  logic [127:0]   core_plaintext
);

    localparam int              FRAME     = K + 128;
    localparam int              CW        = $clog2(FRAME + 2);
    localparam logic [CW-1:0]   CNT_FRAME = CW'(FRAME);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(FRAME + 1);

    logic sck_rise, sck_fall, sck_level_unused;
    logic load_rise, load_fall, load_level_unused;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset(reset), .din(load),
        .level(load_level_unused), .rise(load_rise), .fall(load_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset(reset), .din(sdi),
        .level(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    fe_state_t       state, state_next;
    logic [CW-1:0]   bitcnt, cnt_upd;
    logic [127:0]    outsr, result;
    logic            start_frame, capture, set_err;

    // Count as it will stand after this cycle's sck rise, so a rise that
    // coincides with the load fall is included in the length check.
    always_comb begin
        cnt_upd = bitcnt;
        if (sck_rise && bitcnt != CNT_MAX) cnt_upd = bitcnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        ce          = 1'b1;
        host_done   = 1'b0;
        start_frame = 1'b0;
        capture     = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                if (load_rise) begin
                    state_next  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (load_fall) begin
                    if (cnt_upd == CNT_FRAME) begin
                        state_next = WAIT;
                        ce         = 1'b0;
                    end else begin
                        state_next = IDLE;
                        set_err    = 1'b1;
                    end
                end
            end
            WAIT: begin
                ce = 1'b0;
                // A new frame aborts the computation and leaves result alone.
                if (load_rise) begin
                    state_next  = SHIFT;
                    ce          = 1'b1;
                    start_frame = 1'b1;
                end else if (core_done) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DONE: begin
                ce        = 1'b0;
                host_done = 1'b1;
                if (load_rise) begin
                    state_next  = SHIFT;
                    ce          = 1'b1;
                    host_done   = 1'b0;
                    start_frame = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key        <= '0;
            cyphertext <= '0;
            bitcnt     <= '0;
            outsr      <= '0;
            result     <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (start_frame) begin
                bitcnt    <= '0;
                frame_err <= 1'b0;
                outsr     <= result;
            end else if (state == SHIFT) begin
                if (sck_rise) begin
                    {key, cyphertext} <= {key[K-2:0], cyphertext, sdi_s};
                    bitcnt            <= cnt_upd;
                end
                // Zero fill: bits clocked past the plaintext read as 0.
                if (sck_fall) outsr <= {outsr[126:0], 1'b0};
            end
            if (set_err) frame_err <= 1'b1;
            if (capture) result    <= core_plaintext;
        end
    end

    assign sdo = outsr[127];

endmodule

// File: tb/tb_invaes_spi_frontend.sv
// Directed testbench for invaes_spi_frontend: FIPS-197 frame load, capture
// and readback through a stub core, short and long frames, reset in WAIT,
// and an abort by a new frame during WAIT.
module tb_invaes_spi_frontend;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sck = 1'b0, sdi = 1'b0, load = 1'b0;
    logic         sdo, host_done, frame_err, ce;
    logic [127:0] key, cyphertext;
    logic         core_done = 1'b0;
    logic [127:0] core_plaintext = '0;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY3 = 128'hffffffffffffffff0000000000000000;
    localparam logic [127:0] CT3  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;

    invaes_spi_frontend #(.K(128)) dut (
        .clk(clk), .reset(reset),
        .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .host_done(host_done), .frame_err(frame_err),
        .ce(ce), .key(key), .cyphertext(cyphertext),
        .core_done(core_done), .core_plaintext(core_plaintext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first n bits of tx (MSB first) and returns what sdo showed
    // just before each sck rise, MSB-aligned in rx.
    task automatic run_frame(input string tag, input logic [299:0] tx, input int n,
                             input bit ok, output logic [299:0] rx);
        rx   = '0;
        load = 1'b1;
        tick(6);
        check({tag, "_ce_mid"}, ce, 1);
        check({tag, "_host_done_mid"}, host_done, 0);
        check({tag, "_frame_err_mid"}, frame_err, 0);
        for (int i = 0; i < n; i++) begin
            sdi = tx[299-i];
            tick(5);
            rx[299-i] = sdo;
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
        end
        tick(5);
        load = 1'b0;
        tick(2);
        check({tag, "_ce_2clk"}, ce, 1);
        tick(1);
        check({tag, "_ce_3clk"}, ce, ok ? 0 : 1);
        tick(1);
        check({tag, "_state"}, dut.state, ok ? WAIT : IDLE);
        check({tag, "_frame_err"}, frame_err, ok ? 0 : 1);
    endtask

    task automatic core_finish(input string tag, input logic [127:0] pt);
        core_plaintext = pt;
        core_done      = 1'b1;
        check({tag, "_host_done_pre"}, host_done, 0);
        tick(1);
        check({tag, "_host_done"}, host_done, 1);
        check({tag, "_ce_done"}, ce, 0);
        check({tag, "_result"}, dut.result, pt);
        core_done = 1'b0;
        tick(2);
    endtask

    logic [299:0] rx;
    logic [299:0] tx_long;

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_ce", ce, 1);
        check("rst_host_done", host_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_sdo", sdo, 0);
        check("rst_key", key, 0);
        check("rst_ct", cyphertext, 0);
        check("rst_state", dut.state, IDLE);

        // FIPS-197 key and ciphertext
        run_frame("fips", {KEY1, CT1, 44'h0}, 256, 1'b1, rx);
        check("fips_key", key, KEY1);
        check("fips_ct", cyphertext, CT1);
        tick(10);
        check("fips_wait_ce", ce, 0);

        core_finish("cap1", PT1);

        // readback of PT1 while loading the next key/ciphertext
        run_frame("rdbk", {KEY2, CT2, 44'h0}, 256, 1'b1, rx);
        check("rdbk_sdo", rx[299 -: 128], PT1);
        check("rdbk_key", key, KEY2);
        check("rdbk_ct", cyphertext, CT2);

        // new frame during WAIT aborts; result and readback stay PT1
        run_frame("abort", {KEY3, CT3, 44'h0}, 256, 1'b1, rx);
        check("abort_sdo", rx[299 -: 128], PT1);
        check("abort_result", dut.result, PT1);
        check("abort_key", key, KEY3);

        // reset while in WAIT
        check("rstw_ce_pre", ce, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstw_ce", ce, 1);
        check("rstw_host_done", host_done, 0);
        check("rstw_key", key, 0);
        check("rstw_ct", cyphertext, 0);
        check("rstw_state", dut.state, IDLE);

        // 255-bit frame
        run_frame("short", {KEY1, CT1, 44'h0}, 255, 1'b0, rx);
        check("short_bitcnt", dut.bitcnt, 255);

        // correct frame clears frame_err, then a fresh result
        run_frame("good", {KEY1, CT1, 44'h0}, 256, 1'b1, rx);
        check("good_key", key, KEY1);
        check("good_ct", cyphertext, CT1);
        core_finish("cap2", PT2);

        // 300-bit frame: saturated count, zeros after the plaintext
        tx_long = {75{4'ha}};
        run_frame("long", tx_long, 300, 1'b0, rx);
        check("long_sdo", rx[299 -: 128], PT2);
        check("long_sdo_zero", rx[171:0], 0);
        check("long_bitcnt", dut.bitcnt, 257);
        check("long_host_done", host_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
